// File: rtl/dmem_bus_bridge.sv
// Memory-stage bridge to a valid/ready data bus: one bus transaction per load/store,
// with lane steering, load extension, alignment/func3 checks and a REQ+WAIT timeout.
module dmem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memReadM,
    input  logic        memWriteM,
    input  logic [2:0]  func3M,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    output logic [31:0] rdataM,
    output logic        stallM,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_valid, r_we, r_fault;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_cause;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;

    logic        w_req, w_illegal, w_misal;
    logic [31:0] w_wdata, w_load, w_shift;
    logic [3:0]  w_wstrb;

    assign w_req     = memReadM | memWriteM;
    assign w_illegal = (func3M == 3'b011) || (func3M[2:1] == 2'b11) || (memWriteM && func3M[2]);
    assign w_misal   = (func3M[1:0] == 2'b01 && addrM[0]) ||
                       (func3M[1:0] == 2'b10 && addrM[1:0] != 2'b00);

    always_comb begin
        w_wdata = wdataM;
        w_wstrb = 4'b1111;
        case (func3M[1:0])
            2'b00: begin
                w_wdata = {4{wdataM[7:0]}};
                w_wstrb = 4'b0001 << addrM[1:0];
            end
            2'b01: begin
                w_wdata = {2{wdataM[15:0]}};
                w_wstrb = 4'b0011 << addrM[1:0];
            end
            default: ;
        endcase
    end

    // Load extension uses the offset and size latched at request time.
    assign w_shift = bus_rdata >> {r_off, 3'b000};
    always_comb begin
        case (r_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = bus_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
            r_cause <= 2'b00;
            r_f3    <= '0;
            r_off   <= '0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_rdata <= '0;
                    r_cnt   <= '0;
                    if (w_illegal || w_misal) begin
                        r_cause <= w_illegal ? 2'b11 : 2'b01;
                        r_fault <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cause <= 2'b00;
                        r_valid <= 1'b1;
                        r_we    <= memWriteM;
                        r_addr  <= {addrM[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_wstrb <= memWriteM ? w_wstrb : 4'b0000;
                        r_f3    <= func3M;
                        r_off   <= addrM[1:0];
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_ready && r_we) begin
                        r_valid <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_valid <= 1'b0;
                        r_cause <= 2'b10;
                        r_fault <= 1'b1;
                        r_state <= S_DONE;
                    end else if (bus_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_rvalid) begin
                        r_rdata <= w_load;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cause <= 2'b10;
                        r_fault <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stallM      = (r_state == S_IDLE && w_req) || r_state == S_REQ || r_state == S_WAIT;
    assign rdataM      = r_rdata;
    assign fault       = r_fault;
    assign fault_cause = r_cause;
    assign bus_valid   = r_valid;
    assign bus_we      = r_we;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign bus_wstrb   = r_wstrb;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge: a transaction-level model predicts every
// output each cycle; a few literal checks pin the model to hand-computed values.
module tb_dmem_bus_bridge;
    localparam int TO = 16;

    logic        clock = 1'b0, reset = 1'b1;
    logic        memReadM = 1'b0, memWriteM = 1'b0;
    logic [2:0]  func3M = '0;
    logic [31:0] addrM = '0, wdataM = '0;
    logic [31:0] rdataM;
    logic        stallM, fault;
    logic [1:0]  fault_cause;
    logic        bus_valid, bus_we;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
    logic [3:0]  bus_wstrb;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .memReadM(memReadM), .memWriteM(memWriteM),
        .func3M(func3M), .addrM(addrM), .wdataM(wdataM), .rdataM(rdataM),
        .stallM(stallM), .fault(fault), .fault_cause(fault_cause),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    logic chk_on = 1'b0;

    logic        e_stall = 0, e_valid = 0, e_fault = 0, e_we = 0, e_wd_chk = 0;
    logic [1:0]  e_cause = 0;
    logic [31:0] e_rdata = 0, e_addr = 0, e_wdata = 0;
    logic [3:0]  e_wstrb = 0;
    logic [31:0] m_rdata = 0;
    logic [1:0]  m_cause = 0;

    logic [31:0] d_rdata, d_wdata, d_addr;
    logic [3:0]  d_wstrb;
    logic [1:0]  d_cause;
    int          d_stalls, d_valids, d_faults;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) if (chk_on) begin
        chk("stallM", {31'd0, stallM}, {31'd0, e_stall});
        chk("bus_valid", {31'd0, bus_valid}, {31'd0, e_valid});
        chk("fault", {31'd0, fault}, {31'd0, e_fault});
        chk("fault_cause", {30'd0, fault_cause}, {30'd0, e_cause});
        chk("rdataM", rdataM, e_rdata);
        if (e_valid) begin
            chk("bus_we", {31'd0, bus_we}, {31'd0, e_we});
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e_wstrb});
            if (e_wd_chk) chk("bus_wdata", bus_wdata, e_wdata);
        end
    end

    task automatic cyc();
        @(negedge clock);
        if (stallM) d_stalls++;
        if (bus_valid) begin
            d_valids++;
            d_wdata = bus_wdata; d_wstrb = bus_wstrb; d_addr = bus_addr;
        end
        if (fault) d_faults++;
        d_rdata = rdataM;
        d_cause = fault_cause;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * off);
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            memReadM = 0; memWriteM = 0;
            bus_ready = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            e_stall = 0; e_valid = 0; e_fault = 0; e_cause = m_cause; e_rdata = m_rdata;
            cyc();
        end
        bus_ready = 0; bus_rvalid = 0;
    endtask

    task automatic access(input bit rd, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int rdy, input int rv, input logic [31:0] rword);
        bit ill, mis, tmo;
        int nb, off, n, k, ph;
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (!rd && f3[2]);
        mis = !ill && ((nb == 2 && a[0]) || (nb == 4 && off != 0));
        d_stalls = 0; d_valids = 0; d_faults = 0;
        memReadM = rd; memWriteM = !rd; func3M = f3; addrM = a; wdataM = wd;
        bus_ready = 0; bus_rvalid = 0;
        e_stall = 1; e_valid = 0; e_fault = 0; e_cause = m_cause; e_rdata = m_rdata;
        cyc();
        m_rdata = 0;
        if (ill || mis) begin
            m_cause = ill ? 2'd3 : 2'd1;
            e_fault = 1;
        end else begin
            m_cause = 0;
            e_we = !rd; e_addr = {a[31:2], 2'b00}; e_wd_chk = !rd;
            for (int i = 0; i < 4; i++) begin
                e_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
                e_wstrb[i] = !rd && (i >= off) && (i < off + nb);
            end
            n = 0; k = 0; ph = 1; tmo = 0;
            while (ph != 3) begin
                bus_ready  = (ph == 1 && k == rdy);
                bus_rvalid = (ph == 2 && k == rv);
                bus_rdata  = bus_rvalid ? rword : $urandom;
                e_stall = 1; e_valid = (ph == 1); e_fault = 0; e_cause = 0; e_rdata = 0;
                cyc();
                n++; k++;
                if (ph == 1 && bus_ready && !rd) ph = 3;
                else if (ph == 2 && bus_rvalid) begin ph = 3; m_rdata = ext(f3, a[1:0], rword); end
                else if (n == TO) begin ph = 3; tmo = 1; end
                else if (ph == 1 && bus_ready) begin ph = 2; k = 0; end
            end
            bus_ready = 0; bus_rvalid = 0;
            if (tmo) m_cause = 2'd2;
            e_fault = tmo;
        end
        memReadM = 0; memWriteM = 0;
        e_stall = 0; e_valid = 0; e_cause = m_cause; e_rdata = m_rdata;
        cyc();
        e_fault = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd;
        logic [2:0] f3;
        logic [31:0] a;
        int nb, rdy, rv;
        reset = 1;
        @(posedge clock); #1;
        chk_on = 1;
        cyc();
        reset = 0;
        idle(2);

        access(0, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        chk("sw_stalls", d_stalls, 2);
        chk("sw_valids", d_valids, 1);
        chk("sw_faults", d_faults, 0);

        access(0, 3'd0, 32'h203, 32'h0000005A, 1, 0, 0);
        chk("sb_wdata", d_wdata, 32'h5A5A5A5A);
        chk("sb_wstrb", {28'd0, d_wstrb}, 32'h8);
        chk("sb_addr", d_addr, 32'h200);

        access(1, 3'd0, 32'h102, 0, 0, 0, 32'h0080_0000);
        chk("lb_data", d_rdata, 32'hFFFFFF80);
        access(1, 3'd4, 32'h102, 0, 0, 1, 32'h0080_0000);
        chk("lbu_data", d_rdata, 32'h00000080);
        access(1, 3'd5, 32'h102, 0, 2, 0, 32'h0080_0000);
        chk("lhu_data", d_rdata, 32'h00000080);

        access(1, 3'd2, 32'h40, 0, 0, 5, 32'hCAFEF00D);
        chk("lw_stalls", d_stalls, 8);
        chk("lw_data", d_rdata, 32'hCAFEF00D);

        access(1, 3'd2, 32'h102, 0, 0, 0, 32'h11111111);
        chk("mis_valids", d_valids, 0);
        chk("mis_stalls", d_stalls, 1);
        chk("mis_faults", d_faults, 1);
        chk("mis_cause", {30'd0, d_cause}, 32'd1);
        chk("mis_data", d_rdata, 32'd0);

        access(0, 3'd4, 32'h104, 32'h1, 0, 0, 0);
        chk("ill_cause", {30'd0, d_cause}, 32'd3);

        access(1, 3'd2, 32'h80, 0, 1000, 0, 0);
        chk("tmo_cause", {30'd0, d_cause}, 32'd2);
        chk("tmo_stalls", d_stalls, 17);
        chk("tmo_faults", d_faults, 1);
        idle(1);

        // Abandon a load in WAIT with reset; a late rvalid afterwards must be ignored.
        access(1, 3'd2, 32'h44, 0, 0, 0, 32'h89ABCDEF);
        memReadM = 1; func3M = 3'd2; addrM = 32'h300;
        e_stall = 1; e_valid = 0; e_cause = m_cause; e_rdata = m_rdata;
        cyc();
        bus_ready = 1; e_valid = 1; e_we = 0; e_addr = 32'h300; e_wstrb = 0; e_wd_chk = 0;
        e_cause = 0; e_rdata = 0;
        cyc();
        bus_ready = 0; e_valid = 0;
        cyc();
        reset = 1; memReadM = 0;
        cyc();
        reset = 0; m_rdata = 0; m_cause = 0;
        e_stall = 0; e_cause = 0; e_rdata = 0;
        bus_rvalid = 1; bus_rdata = 32'h12345678;
        cyc();
        bus_rvalid = 0;
        cyc();
        chk("rst_rdata", d_rdata, 32'd0);
        idle(1);

        for (int t = 0; t < 200; t++) begin
            rd = 1'($urandom);
            if ($urandom_range(0, 99) < 85) begin
                if (rd) begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                    endcase
                end else f3 = 3'($urandom_range(0, 2));
            end else f3 = 3'($urandom);
            nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~(32'(nb) - 32'd1);
            rdy = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 3);
            rv  = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 3);
            access(rd, f3, a, $urandom, rdy, rv, $urandom);
            idle($urandom_range(0, 2));
        end

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Data-memory bus bridge between the Memory stage of the pipelined RISC-V core and an external single-port data memory with a valid/ready request channel and an rvalid response channel. It turns each load or store presented by the Memory stage into one bus transaction and stalls the pipeline until that transaction completes. It also performs byte and halfword lane steering, load sign- and zero-extension, misalignment checks and a bus timeout.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ+WAIT before a timeout fault. Must be ≥2.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- memReadM  in  1  load request from the Memory stage.
- memWriteM  in  1  store request from the Memory stage. Never asserted together with memReadM.
- func3M  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU and HU are loads only).
- addrM  in  32  byte address (ALU result).
- wdataM  in  32  store data; the low bytes are used according to size.
- rdataM  out  32  extended load data; valid in the DONE cycle.
- stallM  out  1  pipeline hold; when 1, every pipeline register must hold its value.
- fault  out  1  1-cycle pulse in DONE when the access failed.
- fault_cause  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal func3. Held until the next access starts.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address {addrM[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables. All zeros on reads.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read word.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - When memReadM or memWriteM is asserted, the block checks the access.
  - A legal access latches the bus fields into registers and moves to REQ.
  - A misaligned access (H with addrM[0]=1, W with addrM[1:0]≠0) or an illegal func3 (011, 110, 111, or 100/101 on a store) moves to DONE with fault_cause set. No bus activity occurs.
- REQ:
  - bus_valid=1 and all bus fields are held stable until bus_ready.
  - On the handshake, a write moves to DONE and a read moves to WAIT.
- WAIT: when bus_rvalid=1, bus_rdata is captured and extended into rdataM, then the FSM moves to DONE.
- DONE: stallM=0, so the pipeline advances on this edge. fault pulses if a fault occurred. Next state is IDLE.
- Timeout:
  - A counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, the FSM moves to DONE with cause 10, rdataM=0 and bus_valid dropped.
  - A late bus_rvalid arriving in IDLE is ignored.
- stallM = (IDLE & (memReadM|memWriteM)) | REQ | WAIT. It is combinational.
- Store lanes:
  - SB: wdata = {4{wdataM[7:0]}}, wstrb = 0001 << addrM[1:0].
  - SH: wdata = {2{wdataM[15:0]}}, wstrb = 0011 << addrM[1:0].
  - SW: wdata = wdataM, wstrb = 1111.
- Loads: the byte or halfword is selected by addrM[1:0], then sign-extended (B, H) or zero-extended (BU, HU). Faulted loads return rdataM=0.
- rdataM and fault_cause hold their values from DONE until the next access leaves IDLE.

## Timing
- Reset values: state IDLE, stallM=0, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, rdataM=0, fault=0, fault_cause=00, counter 0.
- A reset asserted in any state returns the FSM to IDLE at that edge and drops bus_valid in the next cycle. The transaction is abandoned and no fault is raised.
- Minimum store latency is 2 stall cycles: IDLE, then REQ with bus_ready=1, then DONE.
- Minimum load latency is 3 stall cycles: IDLE, REQ, then WAIT with rvalid.
- bus_rvalid is only sampled in WAIT, so read data earliest arrives the cycle after the handshake.
- A faulting access costs 1 stall cycle (IDLE to DONE).
- Back-to-back accesses: after DONE, the next instruction's request is seen in IDLE one cycle later. There is no bubble beyond that cycle.

## Test plan
- SW to addr 0x100, data 0xDEADBEEF, bus_ready=1 immediately → bus_valid for 1 cycle with we=1, addr 0x100, wstrb 1111. stallM high for 2 cycles. fault=0.
- SB of 0x5A to addr 0x203 → wdata 0x5A5A5A5A, wstrb 1000, addr 0x200.
- LB from 0x102 with bus_rdata 0x0080_0000 → rdataM 0xFFFFFF80. LBU returns 0x00000080. LHU from 0x102 returns 0x00000080.
- LW with rvalid delayed 5 cycles → stallM high for 8 cycles, then rdataM equals bus_rdata in DONE.
- LW at addr 0x102 → no bus_valid, 1 stall cycle, fault pulse, cause 01, rdataM 0. With TIMEOUT_CYCLES=16 and bus_ready never asserted → cause 10 after 16 REQ cycles.
- reset asserted while in WAIT → IDLE next cycle, bus_valid=0, stallM=0. A subsequent rvalid does not change rdataM.
